// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered result/flags and an iterative
// one-bit-per-cycle shifter; accepts one op in IDLE, holds it in DONE.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);
   localparam int M   = WIDTH - 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_NOT  = 4'd2,
      OP_AND  = 4'd3,
      OP_OR   = 4'd4,
      OP_XOR  = 4'd5,
      OP_SLT  = 4'd6,
      OP_EQ   = 4'd7,
      OP_SLL  = 4'd8,
      OP_SRL  = 4'd9,
      OP_SRA  = 4'd10,
      OP_SLTU = 4'd11
   } op_t;

   state_t           state, state_next;
   logic [3:0]       op_r;
   logic [WIDTH-1:0] work;
   logic [SHW-1:0]   cnt;

   logic [WIDTH:0]   add_full, sub_full;
   logic             add_ovf, sub_ovf;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v;
   logic             is_shift;
   logic [WIDTH-1:0] shifted;
   logic [SHW-1:0]   shamt;

   assign shamt    = b[SHW-1:0];
   assign add_full = {1'b0, a} + {1'b0, b};
   assign sub_full = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
   assign add_ovf  = (a[M] == b[M]) && (add_full[M] != a[M]);
   assign sub_ovf  = (a[M] != b[M]) && (sub_full[M] != a[M]);
   assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res = add_full[M:0];
            alu_c   = add_full[WIDTH];
            alu_v   = add_ovf;
         end
         OP_SUB: begin
            alu_res = sub_full[M:0];
            alu_c   = sub_full[WIDTH];
            alu_v   = sub_ovf;
         end
         OP_NOT: alu_res = ~a;
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         // compare ops report the flags of the underlying subtraction
         OP_SLT: begin
            alu_res = {{(WIDTH-1){1'b0}}, sub_full[M] ^ sub_ovf};
            alu_c   = sub_full[WIDTH];
            alu_v   = sub_ovf;
         end
         OP_EQ: begin
            alu_res = {{(WIDTH-1){1'b0}}, a == b};
            alu_c   = sub_full[WIDTH];
            alu_v   = sub_ovf;
         end
         OP_SLTU: begin
            alu_res = {{(WIDTH-1){1'b0}}, ~sub_full[WIDTH]};
            alu_c   = sub_full[WIDTH];
            alu_v   = sub_ovf;
         end
         default: ;
      endcase
   end

   always_comb begin
      shifted = work;
      case (op_r)
         OP_SLL:  shifted = {work[M-1:0], 1'b0};
         OP_SRL:  shifted = {1'b0, work[M:1]};
         OP_SRA:  shifted = {work[M], work[M:1]};
         default: ;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = (is_shift && shamt != '0) ? SHIFT : DONE;
         SHIFT:   if (cnt == SHW'(1)) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r   <= '0;
         work   <= '0;
         cnt    <= '0;
         result <= '0;
         flag_z <= 1'b0;
         flag_n <= 1'b0;
         flag_c <= 1'b0;
         flag_v <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               op_r <= op;
               work <= a;
               cnt  <= shamt;
               if (!is_shift) begin
                  result <= alu_res;
                  flag_z <= (alu_res == '0);
                  flag_n <= alu_res[M];
                  flag_c <= alu_c;
                  flag_v <= alu_v;
               end else if (shamt == '0) begin
                  result <= a;
                  flag_z <= (a == '0);
                  flag_n <= a[M];
                  flag_c <= 1'b0;
                  flag_v <= 1'b0;
               end
            end
            SHIFT: begin
               work <= shifted;
               cnt  <= cnt - SHW'(1);
               if (cnt == SHW'(1)) begin
                  result <= shifted;
                  flag_z <= (shifted == '0);
                  flag_n <= shifted[M];
                  flag_c <= 1'b0;
                  flag_v <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8): ALU ops, iterative
// shifts with latency, backpressure and asynchronous reset during SHIFT.
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] op;
   logic [7:0] a;
   logic [7:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       flag_z, flag_n, flag_c, flag_v;
   logic       busy;

   int checks = 0;
   int fails  = 0;

   alu_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flag_z    (flag_z),
      .flag_n    (flag_n),
      .flag_c    (flag_c),
      .flag_v    (flag_v),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [3:0] zncv;
      int         lat;
   } vec_t;

   // drive one request, called #1 after an edge while in IDLE
   task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
      #12;
      checks++;
      if ({result, flag_z, flag_n, flag_c, flag_v} !== 12'h000) begin
         fails++; $display("FAIL reset_regs: got %h/%b want 00/0000", result, {flag_z, flag_n, flag_c, flag_v});
      end
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
         fails++; $display("FAIL reset_hs: got ov/ir/busy=%b want 010", {out_valid, in_ready, busy});
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_ops();
      vec_t v[14];
      v[0]  = '{4'd0,  8'h7F, 8'h01, 8'h80, 4'b0101, 1};
      v[1]  = '{4'd1,  8'h05, 8'h05, 8'h00, 4'b1010, 1};
      v[2]  = '{4'd7,  8'h05, 8'h05, 8'h01, 4'b0010, 1};
      v[3]  = '{4'd6,  8'h80, 8'h01, 8'h01, 4'b0011, 1};
      v[4]  = '{4'd11, 8'h80, 8'h01, 8'h00, 4'b1011, 1};
      v[5]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 4'b1010, 1};
      v[6]  = '{4'd2,  8'h5A, 8'h00, 8'hA5, 4'b0100, 1};
      v[7]  = '{4'd3,  8'hF0, 8'h3C, 8'h30, 4'b0000, 1};
      v[8]  = '{4'd4,  8'hF0, 8'h0C, 8'hFC, 4'b0100, 1};
      v[9]  = '{4'd5,  8'hAA, 8'hAA, 8'h00, 4'b1000, 1};
      v[10] = '{4'd12, 8'hFF, 8'hFF, 8'h00, 4'b1000, 1};
      v[11] = '{4'd1,  8'h00, 8'h01, 8'hFF, 4'b0100, 1};
      v[12] = '{4'd11, 8'h00, 8'h01, 8'h01, 4'b0000, 1};
      v[13] = '{4'd1,  8'h80, 8'h01, 8'h7F, 4'b0011, 1};
      for (int i = 0; i < 14; i++) begin
         checks++;
         if (in_ready !== 1'b1) begin
            fails++; $display("FAIL ops_ready[%0d]: got %b want 1", i, in_ready);
         end
         issue(v[i].op, v[i].a, v[i].b);
         checks++;
         if (out_valid !== 1'b1) begin
            fails++; $display("FAIL ops_latency[%0d]: out_valid=%b want 1 at cycle 1", i, out_valid);
         end
         checks++;
         if ({result, flag_z, flag_n, flag_c, flag_v} !== {v[i].res, v[i].zncv}) begin
            fails++; $display("FAIL ops_result[%0d] op=%0d: got %h/%b want %h/%b", i, v[i].op,
                              result, {flag_z, flag_n, flag_c, flag_v}, v[i].res, v[i].zncv);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_shift();
      vec_t v[6];
      v[0] = '{4'd10, 8'h90, 8'h03, 8'hF2, 4'b0100, 4};
      v[1] = '{4'd8,  8'h01, 8'h00, 8'h01, 4'b0000, 1};
      v[2] = '{4'd9,  8'h80, 8'h0F, 8'h01, 4'b0000, 8};
      v[3] = '{4'd8,  8'h81, 8'h09, 8'h02, 4'b0000, 2};
      v[4] = '{4'd10, 8'h40, 8'h02, 8'h10, 4'b0000, 3};
      v[5] = '{4'd8,  8'h80, 8'h01, 8'h00, 4'b1000, 2};
      for (int i = 0; i < 6; i++) begin
         issue(v[i].op, v[i].a, v[i].b);
         for (int c = 1; c < v[i].lat; c++) begin
            checks++;
            if ({in_ready, busy, out_valid} !== 3'b010) begin
               fails++; $display("FAIL shift_busy[%0d] cycle %0d: ir/busy/ov=%b want 010", i, c, {in_ready, busy, out_valid});
            end
            @(posedge clk); #1;
         end
         checks++;
         if (out_valid !== 1'b1) begin
            fails++; $display("FAIL shift_latency[%0d]: out_valid=%b want 1 at cycle %0d", i, out_valid, v[i].lat);
         end
         checks++;
         if ({result, flag_z, flag_n, flag_c, flag_v} !== {v[i].res, v[i].zncv}) begin
            fails++; $display("FAIL shift_result[%0d]: got %h/%b want %h/%b", i,
                              result, {flag_z, flag_n, flag_c, flag_v}, v[i].res, v[i].zncv);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      issue(4'd0, 8'h10, 8'h20);
      checks++;
      if ({out_valid, result} !== {1'b1, 8'h30}) begin
         fails++; $display("FAIL bp_first: ov/result=%b/%h want 1/30", out_valid, result);
      end
      op = 4'd1; a = 8'h09; b = 8'h03; in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         checks++;
         if ({out_valid, in_ready, result, flag_z, flag_n, flag_c, flag_v} !== {2'b10, 8'h30, 4'b0000}) begin
            fails++; $display("FAIL bp_hold[%0d]: ov/ir=%b result=%h flags=%b want 10/30/0000", c,
                              {out_valid, in_ready}, result, {flag_z, flag_n, flag_c, flag_v});
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, result} !== {2'b01, 8'h30}) begin
         fails++; $display("FAIL bp_release: ov/ir=%b result=%h want 01/30", {out_valid, in_ready}, result);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if ({out_valid, result, flag_z, flag_n, flag_c, flag_v} !== {1'b1, 8'h06, 4'b0010}) begin
         fails++; $display("FAIL bp_next: ov=%b result=%h flags=%b want 1/06/0010", out_valid, result,
                           {flag_z, flag_n, flag_c, flag_v});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_shift();
      issue(4'd8, 8'h01, 8'h07);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if ({busy, out_valid} !== 2'b10) begin
         fails++; $display("FAIL rst_pre: busy/ov=%b want 10", {busy, out_valid});
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, result, flag_z, flag_n, flag_c, flag_v} !== 13'h0000) begin
         fails++; $display("FAIL rst_async: ov=%b result=%h flags=%b want 0/00/0000", out_valid, result,
                           {flag_z, flag_n, flag_c, flag_v});
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({in_ready, busy} !== 2'b10) begin
         fails++; $display("FAIL rst_idle: ir/busy=%b want 10", {in_ready, busy});
      end
      issue(4'd0, 8'h03, 8'h04);
      checks++;
      if ({out_valid, result, flag_z, flag_n, flag_c, flag_v} !== {1'b1, 8'h07, 4'b0000}) begin
         fails++; $display("FAIL rst_after_add: ov=%b result=%h flags=%b want 1/07/0000", out_valid, result,
                           {flag_z, flag_n, flag_c, flag_v});
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_ops();
      test_shift();
      test_backpressure();
      test_reset_mid_shift();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
